// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single ram_async port between the CPU bus path and
// the DMA master. Requests are serialised, the RAM strobes are held for a fixed
// RAM_CYCLES because the RAM gives no completion, and the owner gets read data
// plus a one-cycle ack. DMA wins ties until it has taken DMA_BURST grants in a
// row; after that a waiting CPU is served once.
module ram_arbiter #(
  parameter int RAM_CYCLES = 2,
  parameter int DMA_BURST  = 4
) (
  input  logic        clk,
  input  logic        reset,
  // CPU master
  input  logic [21:0] cpu_addr,
  input  logic [15:0] cpu_data_in,
  output logic [15:0] cpu_data_out,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic        cpu_byte_op,
  output logic        cpu_ack,
  // DMA master
  input  logic [21:0] dma_addr,
  input  logic [15:0] dma_data_in,
  output logic [15:0] dma_data_out,
  input  logic        dma_rd,
  input  logic        dma_wr,
  input  logic        dma_byte_op,
  output logic        dma_ack,
  // RAM port
  output logic [21:0] ram_addr,
  output logic [15:0] ram_data_out,
  input  logic [15:0] ram_data_in,
  output logic        ram_rd,
  output logic        ram_wr,
  output logic        ram_byte_op,
  output logic [1:0]  arb_owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  // One master's request as seen by the RAM side
  typedef struct packed {
    logic [21:0] addr;
    logic [15:0] data;
    logic        byte_op;
    logic        rd;       // rd wins when rd and wr are both high
  } req_t;

  localparam logic [3:0] CNT_LOAD  = 4'(RAM_CYCLES - 1);
  localparam logic [3:0] BURST_MAX = 4'(DMA_BURST);
  localparam logic [1:0] OWN_NONE  = 2'b00;
  localparam logic [1:0] OWN_CPU   = 2'b01;
  localparam logic [1:0] OWN_DMA   = 2'b10;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic [3:0] dma_streak;
  logic       cpu_req, dma_req;
  logic       grant_cpu, grant_dma;
  logic       last;
  req_t       sel;

  assign cpu_req = cpu_rd | cpu_wr;
  assign dma_req = dma_rd | dma_wr;
  assign last    = (state == ACCESS) && (cnt == 4'd0);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and grant decision; DMA yields only once its streak is spent
  always_comb begin
    state_nxt = state;
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    case (state)
      IDLE: begin
        if (dma_req && (!cpu_req || dma_streak != BURST_MAX)) begin
          grant_dma = 1'b1;
          state_nxt = ACCESS;
        end else if (cpu_req) begin
          grant_cpu = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS:  if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pick the winning master's request fields
  always_comb begin
    sel = '0;
    if (grant_dma) sel = '{addr: dma_addr, data: dma_data_in, byte_op: dma_byte_op, rd: dma_rd};
    else           sel = '{addr: cpu_addr, data: cpu_data_in, byte_op: cpu_byte_op, rd: cpu_rd};
  end

  // RAM port registers, owner and access timer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_addr     <= '0;
      ram_data_out <= '0;
      ram_rd       <= 1'b0;
      ram_wr       <= 1'b0;
      ram_byte_op  <= 1'b0;
      arb_owner    <= OWN_NONE;
      cnt          <= '0;
    end else begin
      case (state)
        IDLE: if (grant_cpu || grant_dma) begin
          ram_addr     <= sel.addr;
          ram_data_out <= sel.data;
          ram_byte_op  <= sel.byte_op;
          ram_rd       <= sel.rd;
          ram_wr       <= ~sel.rd;
          arb_owner    <= grant_dma ? OWN_DMA : OWN_CPU;
          cnt          <= CNT_LOAD;
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            ram_rd      <= 1'b0;
            ram_wr      <= 1'b0;
            ram_byte_op <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE:    arb_owner <= OWN_NONE;
        default: arb_owner <= OWN_NONE;
      endcase
    end
  end

  // Read capture and completion pulse, only ever touching the owner's side
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_data_out <= '0;
      dma_data_out <= '0;
      cpu_ack      <= 1'b0;
      dma_ack      <= 1'b0;
    end else begin
      cpu_ack <= last && (arb_owner == OWN_CPU);
      dma_ack <= last && (arb_owner == OWN_DMA);
      if (last && ram_rd) begin
        if (arb_owner == OWN_CPU) cpu_data_out <= ram_data_in;
        if (arb_owner == OWN_DMA) dma_data_out <= ram_data_in;
      end
    end
  end

  // DMA streak: saturating count of DMA grants, cleared by a CPU grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      dma_streak <= '0;
    else if (grant_cpu)
      dma_streak <= '0;
    else if (grant_dma && dma_streak != BURST_MAX)
      dma_streak <= dma_streak + 4'd1;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed stimulus against a cycle-level transaction model of
// the arbiter (grant -> RC strobe cycles -> one ack cycle -> back to idle),
// plus literal expectations for the documented scenarios.
module tb_ram_arbiter;
  localparam int RC = 2;
  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [21:0] cpu_addr, dma_addr, ram_addr;
  logic [15:0] cpu_data_in, cpu_data_out, dma_data_in, dma_data_out;
  logic [15:0] ram_data_out, ram_data_in;
  logic        cpu_rd, cpu_wr, cpu_byte_op, cpu_ack;
  logic        dma_rd, dma_wr, dma_byte_op, dma_ack;
  logic        ram_rd, ram_wr, ram_byte_op;
  logic [1:0]  arb_owner;

  always #5 clk = ~clk;

  ram_arbiter #(.RAM_CYCLES(RC), .DMA_BURST(DB)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_byte_op(cpu_byte_op), .cpu_ack(cpu_ack),
    .dma_addr(dma_addr), .dma_data_in(dma_data_in), .dma_data_out(dma_data_out),
    .dma_rd(dma_rd), .dma_wr(dma_wr), .dma_byte_op(dma_byte_op), .dma_ack(dma_ack),
    .ram_addr(ram_addr), .ram_data_out(ram_data_out), .ram_data_in(ram_data_in),
    .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_byte_op(ram_byte_op), .arb_owner(arb_owner)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- transaction model ----------------
  bit          m_busy;
  int          m_k;        // edges elapsed since the grant edge
  int          m_owner;    // 1 CPU, 2 DMA
  bit          m_read, m_byte;
  logic [21:0] m_addr;
  logic [15:0] m_data, m_cpu_dout, m_dma_dout;
  int          m_streak;
  bit          cr, dr, granted;
  int          m_grants[$];
  int          d_grants[$];
  int          prev_owner;
  int          n_rd, n_wr, n_byte, n_cpu_ack, n_dma_ack, n_busy;

  function automatic logic [76:0] dut_vec();
    return {arb_owner, cpu_ack, dma_ack, ram_rd, ram_wr, ram_byte_op,
            ram_addr, ram_data_out, cpu_data_out, dma_data_out};
  endfunction

  function automatic logic [76:0] model_vec();
    logic       strobe, ack;
    logic [1:0] own;
    strobe = m_busy && (m_k < RC);
    ack    = m_busy && (m_k == RC);
    own    = !m_busy ? 2'b00 : (m_owner == 1 ? 2'b01 : 2'b10);
    return {own, ack && m_owner == 1, ack && m_owner == 2,
            strobe && m_read, strobe && !m_read, strobe && m_byte,
            m_addr, m_data, m_cpu_dout, m_dma_dout};
  endfunction

  // Advance the model on each edge, then compare every output shortly after
  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_k = 0; m_owner = 0; m_read = 0; m_byte = 0;
      m_addr = '0; m_data = '0; m_cpu_dout = '0; m_dma_dout = '0;
      m_streak = 0; prev_owner = 0;
    end else if (m_busy) begin
      m_k++;
      if (m_k == RC && m_read) begin
        if (m_owner == 1) m_cpu_dout = ram_data_in;
        else              m_dma_dout = ram_data_in;
      end
      if (m_k > RC) m_busy = 0;
    end else begin
      cr = cpu_rd | cpu_wr;
      dr = dma_rd | dma_wr;
      granted = 0;
      if (dr && !(cr && m_streak == DB)) begin
        m_owner = 2; m_read = dma_rd; m_byte = dma_byte_op;
        m_addr = dma_addr; m_data = dma_data_in;
        m_streak = (m_streak < DB) ? m_streak + 1 : DB;
        granted = 1;
      end else if (cr) begin
        m_owner = 1; m_read = cpu_rd; m_byte = cpu_byte_op;
        m_addr = cpu_addr; m_data = cpu_data_in;
        m_streak = 0;
        granted = 1;
      end
      if (granted) begin
        m_busy = 1; m_k = 0;
        m_grants.push_back(m_owner);
      end
    end
    #1;
    if (!reset) begin
      chk("cycle_outputs", dut_vec(), model_vec());
      chk("one_strobe", ram_rd & ram_wr, 1'b0);
      n_rd += ram_rd; n_wr += ram_wr; n_byte += ram_byte_op;
      n_cpu_ack += cpu_ack; n_dma_ack += dma_ack;
      n_busy += (arb_owner != 2'b00);
      if (arb_owner != 2'b00 && prev_owner == 0) d_grants.push_back(int'(arb_owner));
      prev_owner = int'(arb_owner);
    end
  end

  task automatic clr_counts();
    n_rd = 0; n_wr = 0; n_byte = 0; n_cpu_ack = 0; n_dma_ack = 0; n_busy = 0;
  endtask

  // Wait (bounded) for the given master's ack, sampled mid-cycle
  task automatic wait_ack(input int who);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if ((who == 1 && cpu_ack) || (who == 2 && dma_ack)) return;
    end
    checks++; failures++;
    $display("FAIL ack_timeout master=%0d actual=no_ack required=ack", who);
  endtask

  // Wait (bounded) until the DUT grant log holds at least n entries
  task automatic wait_grants(input int n);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (d_grants.size() >= n) return;
    end
    checks++; failures++;
    $display("FAIL grant_timeout actual=%0d required=%0d", d_grants.size(), n);
  endtask

  int exp_burst[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
  int cpu_cnt;

  initial begin
    reset = 1'b1;
    cpu_addr = '0; cpu_data_in = '0; cpu_rd = 0; cpu_wr = 0; cpu_byte_op = 0;
    dma_addr = '0; dma_data_in = '0; dma_rd = 0; dma_wr = 0; dma_byte_op = 0;
    ram_data_in = '0;
    clr_counts();
    repeat (3) @(negedge clk);
    chk("reset_outputs", dut_vec(), 77'd0);
    reset = 1'b0;

    // idle with no requests
    repeat (10) @(negedge clk);
    chk("idle_owner", n_busy, 0);
    chk("idle_strobes", n_rd + n_wr, 0);

    // CPU read
    clr_counts(); d_grants.delete(); m_grants.delete();
    ram_data_in = 16'o123456; cpu_addr = 22'o001000; cpu_rd = 1;
    wait_ack(1);
    chk("cpu_rd_ack_data", cpu_data_out, 16'o123456);
    cpu_rd = 0;
    repeat (4) @(negedge clk);
    chk("cpu_rd_strobe_cycles", n_rd, 2);
    chk("cpu_rd_no_wr", n_wr, 0);
    chk("cpu_rd_ack_count", n_cpu_ack, 1);
    chk("cpu_rd_dma_ack", n_dma_ack, 0);
    chk("cpu_rd_addr", ram_addr, 22'o001000);
    chk("cpu_rd_period", n_busy, 3);
    chk("cpu_rd_grants", d_grants.size(), 1);

    // DMA byte write
    clr_counts();
    ram_data_in = 16'o177777;
    dma_addr = 22'o017777; dma_data_in = 16'o000377; dma_byte_op = 1; dma_wr = 1;
    wait_ack(2);
    dma_wr = 0; dma_byte_op = 0;
    repeat (4) @(negedge clk);
    chk("dma_wr_strobe_cycles", n_wr, 2);
    chk("dma_wr_byte_cycles", n_byte, 2);
    chk("dma_wr_ack_count", n_dma_ack, 1);
    chk("dma_wr_cpu_ack", n_cpu_ack, 0);
    chk("dma_wr_cpu_data_held", cpu_data_out, 16'o123456);
    chk("dma_wr_data_held", ram_data_out, 16'o000377);
    chk("dma_wr_addr_held", ram_addr, 22'o017777);

    // rd+wr together is a read
    clr_counts();
    ram_data_in = 16'o054321; cpu_addr = 22'o002000; cpu_data_in = 16'o070707;
    cpu_rd = 1; cpu_wr = 1;
    wait_ack(1);
    cpu_rd = 0; cpu_wr = 0;
    repeat (4) @(negedge clk);
    chk("conflict_no_wr", n_wr, 0);
    chk("conflict_rd_cycles", n_rd, 2);
    chk("conflict_ack", n_cpu_ack, 1);
    chk("conflict_data", cpu_data_out, 16'o054321);
    chk("conflict_dma_data", dma_data_out, 16'd0);

    // burst limit with both masters requesting continuously
    d_grants.delete(); m_grants.delete();
    ram_data_in = 16'o111111;
    cpu_addr = 22'o003000; cpu_rd = 1;
    dma_addr = 22'o004000; dma_data_in = 16'o000123; dma_wr = 1;
    wait_grants(10);
    cpu_rd = 0; dma_wr = 0;
    repeat (6) @(negedge clk);
    chk("burst_count", d_grants.size(), 10);
    cpu_cnt = 0;
    for (int i = 0; i < 10 && i < d_grants.size(); i++) begin
      chk($sformatf("burst_dut_grant%0d", i), d_grants[i], exp_burst[i]);
      if (d_grants[i] == 1) cpu_cnt++;
    end
    for (int i = 0; i < 10 && i < m_grants.size(); i++)
      chk($sformatf("burst_model_grant%0d", i), m_grants[i], exp_burst[i]);
    chk("burst_cpu_share", cpu_cnt, 2);
    chk("burst_cpu_data", cpu_data_out, 16'o111111);

    // reset in the middle of an access
    d_grants.delete(); m_grants.delete();
    cpu_rd = 1; dma_wr = 1;
    wait_grants(2);
    for (int c = 0; c < 10 && !(ram_rd || ram_wr); c++) @(negedge clk);
    chk("pre_reset_strobe", ram_rd | ram_wr, 1'b1);
    #2 reset = 1'b1;
    #1 chk("midreset_outputs", dut_vec(), 77'd0);
    @(negedge clk);
    d_grants.delete(); m_grants.delete(); clr_counts();
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_no_ack", cpu_ack | dma_ack, 1'b0);
    wait_grants(5);
    cpu_rd = 0; dma_wr = 0;
    repeat (6) @(negedge clk);
    chk("reissue_count", d_grants.size(), 5);
    for (int i = 0; i < 5 && i < d_grants.size(); i++)
      chk($sformatf("reissue_dut_grant%0d", i), d_grants[i], exp_burst[i]);
    for (int i = 0; i < 5 && i < m_grants.size(); i++)
      chk($sformatf("reissue_model_grant%0d", i), m_grants[i], exp_burst[i]);
    chk("reissue_cpu_ack", n_cpu_ack, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
